serial_add_sub: RTL
===================

# serial_add_sub

Bit-serial 8-bit add/subtract unit for the ALU. It produces A+B, or A−B as the two's-complement negation of B (~B + 1) added to A. It processes one bit per clock so a single full-adder cell is shared across all bit positions. It sits in the ALU datapath alongside the combinational negation/adder path as the low-area arithmetic option, feeding the result/flag register stage with a start/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = A+B, 1 = A−B; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse: result/flags valid
- result  out  WIDTH  sum/difference
- carry  out  1  final carry out (subtract: 1 = no borrow, A ≥ B unsigned)
- overflow  out  1  signed overflow
- zero  out  1  result == 0
- negative  out  1  result[WIDTH−1]

## Operation
- States: IDLE, RUN, DONE.
- **IDLE, start=1:**
  - Latch a_sh=a and b_sh=(op ? ~b : b).
  - Set carry register c=op, bit counter cnt=0, partial sum cleared.
  - Go to RUN.
- **IDLE, start=0:** hold. Outputs keep their last values.
- **RUN, each cycle:**
  - Full-add a_sh[0], b_sh[0], c. Shift the sum bit into the partial sum MSB (right-shift register).
  - Right-shift a_sh and b_sh; c ← carry out; cnt++.
  - Record the carry-in of bit WIDTH−1 when cnt==WIDTH−1.
- **RUN, last bit (cnt==WIDTH−1):**
  - Update result, carry, overflow (carry-in of MSB XOR carry out), zero and negative on the same edge.
  - Go to DONE.
- **DONE:** done=1 for this one cycle, then unconditionally go to IDLE.
- **Busy behaviour:** start is ignored in RUN and DONE. No queuing, and a, b, op changes have no effect.
- **Output hold:** result and flags hold until the last-bit edge of the next operation. They never show partial sums.
- **Arithmetic:** modulo 2^WIDTH; all flags are computed over exactly WIDTH bits.
- **Negation:** a=0, op=1 yields −b.
- **Reset (any time, including mid-RUN):**
  - Go to IDLE.
  - Clear all internal registers.
  - result=0, carry=overflow=zero=negative=0, busy=0, done=0.
  - An aborted operation never asserts done.

## Timing
- Start accepted on edge E0 → busy=1 after E0.
- Bits are processed on edges E1..E_WIDTH. Outputs are updated at E_WIDTH.
- done=1 between E_WIDTH and E_WIDTH+1, then busy=0 after E_WIDTH+1.
- WIDTH=8: done is visible 8 cycles after the start edge.
- Minimum start-to-start spacing: WIDTH+2 edges. A start held high in DONE is not accepted; it is accepted at the first IDLE edge.
- Reset values: all outputs 0; state IDLE.

## Structure
- Shared package `alu_pkg`:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - OP_ADD=1'b0, OP_SUB=1'b1
  - default WIDTH
- One sub-module: `full_adder` (1-bit, a/b/cin → s/cout), instantiated once.
- Counter width: clog2(WIDTH).

## Test plan
- 0x05 + 0x03, op=0 → result 0x08, carry 0, overflow 0, zero 0, negative 0; done exactly 8 edges after start, one cycle wide.
- 0x03 − 0x05 → 0xFE, carry 0, negative 1, overflow 0; 0x2A − 0x2A → 0x00, zero 1, carry 1.
- 0x80 − 0x01 → 0x7F, overflow 1, carry 1; 0x7F + 0x01 → 0x80, overflow 1, negative 1, carry 0.
- Negation edge: 0x00 − 0x80 → 0x80, overflow 1, carry 0, negative 1; 0xFF + 0x01 → 0x00, carry 1, zero 1, overflow 0.
- Start pulsed with different a/b during RUN → ignored; result matches the first operands; busy never drops early.
- rst_n low at cycle 4 of RUN → all outputs 0 immediately, no done pulse; a fresh 0x10 − 0x01 after release → 0x0F with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM encodings, opcodes, default width and flag bundle.
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Status flags published with each result
  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the single arithmetic cell shared by every bit position.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one bit per clock through a shared full adder,
// with result and flags published together on the last-bit edge.
module serial_add_sub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned     CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] psum_q,   psum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             c_q,      c_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  flags_t           flags_q,  flags_d;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;

  // Shared adder cell operating on the current LSBs and the running carry
  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Partial sum after this cycle's bit enters at the MSB
  assign sum_next = {fa_s, psum_q[WIDTH-1:1]};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      psum_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      psum_q   <= psum_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      flags_q  <= flags_d;
    end
  end

  // Next-state and next-output logic; at the MSB step c_q is the MSB carry-in
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    psum_d   = psum_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    flags_d  = flags_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = (op == OP_SUB) ? ~b : b;
          c_d     = op;
          cnt_d   = '0;
          psum_d  = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        psum_d = sum_next;
        c_d    = fa_cout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          result_d         = sum_next;
          flags_d.carry    = fa_cout;
          flags_d.overflow = c_q ^ fa_cout;
          flags_d.zero     = (sum_next == '0);
          flags_d.negative = fa_s;
          done_d           = 1'b1;
          state_d          = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;

endmodule
